// File: rtl/simon128_256_decrypt.sv
// Iterative Simon128/256 decryption core.
//
// Takes one 128-bit ciphertext block {x, y} and applies NUM_ROUNDS inverse Feistel rounds,
// consuming round keys from the shared pre-expanded key memory in descending order
// (k[NUM_ROUNDS-1] first, k[0] last). Produces the plaintext on a valid/ready stream.
// One block is in flight at a time.
//
// Optional feature (macro SIMON128_256_DECRYPT_KEY_CHECK_EN):
//   When defined, a round cycle that sees key_data_vld low sets a sticky error bit that
//   is reported on pt_err alongside the result. When undefined, key_data_vld is ignored
//   and pt_err is tied low.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   key_mem_full   key memory loaded; gates acceptance of new ciphertext
//   key_rd_en      registered key memory read strobe
//   key_addr       registered key memory address
//   key_data       round key, valid the cycle after key_rd_en/key_addr
//   key_data_vld   read-data valid (only used with the optional feature)
//   ct_data/vld/rdy  ciphertext input stream {x[127:64], y[63:0]}
//   pt_data/vld/rdy  plaintext output stream {x, y}
//   pt_err         key-read error flag for the presented result
module simon128_256_decrypt #(
  parameter int unsigned NUM_ROUNDS     = 72,
  parameter int unsigned KEY_ADDR_WIDTH = 9,
  parameter int unsigned KEY_BASE_ADDR  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_mem_full,
  output logic                      key_rd_en,
  output logic [KEY_ADDR_WIDTH-1:0] key_addr,
  input  logic [63:0]               key_data,
  input  logic                      key_data_vld,
  input  logic [127:0]              ct_data,
  input  logic                      ct_vld,
  output logic                      ct_rdy,
  output logic [127:0]              pt_data,
  output logic                      pt_vld,
  input  logic                      pt_rdy,
  output logic                      pt_err
);

  localparam logic [KEY_ADDR_WIDTH-1:0] BaseAddr  = KEY_ADDR_WIDTH'(KEY_BASE_ADDR);
  localparam logic [KEY_ADDR_WIDTH-1:0] LastAddr  =
      KEY_ADDR_WIDTH'(KEY_BASE_ADDR + NUM_ROUNDS - 1);
  localparam logic [KEY_ADDR_WIDTH-1:0] AddrOne   = KEY_ADDR_WIDTH'(1);
  localparam logic [6:0]                LastRound = 7'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StRound,
    StDone
  } state_e;

  state_e                    state_q, state_d;
  logic [63:0]               x_q, x_d;
  logic [63:0]               y_q, y_d;
  logic [6:0]                round_q, round_d;
  logic                      key_rd_en_q, key_rd_en_d;
  logic [KEY_ADDR_WIDTH-1:0] key_addr_q, key_addr_d;
  logic                      pt_vld_q, pt_vld_d;
  logic                      accept;
  logic                      addr_last;

  // Simon round function: (rotl1 & rotl8) ^ rotl2.
  function automatic logic [63:0] simon_f(input logic [63:0] v);
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] r8;
    r1 = {v[62:0], v[63]};
    r2 = {v[61:0], v[63:62]};
    r8 = {v[55:0], v[63:56]};
    return (r1 & r8) ^ r2;
  endfunction

  // Ready only in IDLE with the key memory loaded; forced low during reset.
  assign ct_rdy    = (state_q == StIdle) && key_mem_full && !rst;
  assign accept    = ct_vld && ct_rdy;
  assign addr_last = (key_addr_q == BaseAddr);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    round_d     = round_q;
    key_rd_en_d = key_rd_en_q;
    key_addr_d  = key_addr_q;
    pt_vld_d    = pt_vld_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          x_d         = ct_data[127:64];
          y_d         = ct_data[63:0];
          key_rd_en_d = 1'b1;
          key_addr_d  = LastAddr;
          round_d     = LastRound;
          state_d     = StPrime;
        end
      end

      StPrime: begin
        // First key is in flight; issue the second address.
        if (key_rd_en_q) begin
          if (addr_last) begin
            key_rd_en_d = 1'b0;
          end else begin
            key_addr_d = key_addr_q - AddrOne;
          end
        end
        state_d = StRound;
      end

      StRound: begin
        // Address issue runs one cycle ahead of key consumption.
        if (key_rd_en_q) begin
          if (addr_last) begin
            key_rd_en_d = 1'b0;
          end else begin
            key_addr_d = key_addr_q - AddrOne;
          end
        end
        x_d = y_q;
        y_d = x_q ^ simon_f(y_q) ^ key_data;
        if (round_q == 7'd0) begin
          state_d  = StDone;
          pt_vld_d = 1'b1;
        end else begin
          round_d = round_q - 7'd1;
        end
      end

      StDone: begin
        // pt_vld is always high here, so pt_rdy alone completes the handshake.
        if (pt_rdy) begin
          pt_vld_d = 1'b0;
          state_d  = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= 64'd0;
      y_q         <= 64'd0;
      round_q     <= 7'd0;
      key_rd_en_q <= 1'b0;
      key_addr_q  <= '0;
      pt_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      round_q     <= round_d;
      key_rd_en_q <= key_rd_en_d;
      key_addr_q  <= key_addr_d;
      pt_vld_q    <= pt_vld_d;
    end
  end

  assign key_rd_en = key_rd_en_q;
  assign key_addr  = key_addr_q;
  assign pt_data   = {x_q, y_q};
  assign pt_vld    = pt_vld_q;

`ifdef SIMON128_256_DECRYPT_KEY_CHECK_EN
  logic err_q, err_d;

  // Sticky per block: cleared by the accept that starts a new block.
  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if ((state_q == StRound) && !key_data_vld) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign pt_err = pt_vld_q & err_q;
`else
  logic unused_key_data_vld;
  assign unused_key_data_vld = key_data_vld;
  assign pt_err              = 1'b0;
`endif

endmodule

// File: tb/tb_simon128_256_decrypt.sv
module tb_simon128_256_decrypt;

  localparam int NR = 72;
  localparam logic [255:0] KAT_KEY =
      256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] KAT_CT = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;
  localparam logic [127:0] KAT_PT = 128'h74206e69206d6f6f_6d69732061207369;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_mem_full;
  logic         key_rd_en;
  logic [8:0]   key_addr;
  logic [63:0]  key_data;
  logic         key_data_vld;
  logic [127:0] ct_data;
  logic         ct_vld;
  logic         ct_rdy;
  logic [127:0] pt_data;
  logic         pt_vld;
  logic         pt_rdy;
  logic         pt_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0]  mem [0:511];
  logic [63:0]  rk  [0:NR-1];
  logic [127:0] exp_q [$];

  simon128_256_decrypt dut (
    .clk          (clk),
    .rst          (rst),
    .key_mem_full (key_mem_full),
    .key_rd_en    (key_rd_en),
    .key_addr     (key_addr),
    .key_data     (key_data),
    .key_data_vld (key_data_vld),
    .ct_data      (ct_data),
    .ct_vld       (ct_vld),
    .ct_rdy       (ct_rdy),
    .pt_data      (pt_data),
    .pt_vld       (pt_vld),
    .pt_rdy       (pt_rdy),
    .pt_err       (pt_err)
  );

  always #5 clk = ~clk;

  // Key memory with one cycle of read latency.
  always @(posedge clk) begin
    if (key_rd_en) key_data <= mem[key_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] fr(input logic [63:0] v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

  task automatic expand_key(input logic [255:0] key);
    logic [63:0] z;
    logic [63:0] tmp;
    z     = 64'hfdc94c3a046d678b;
    rk[0] = key[63:0];
    rk[1] = key[127:64];
    rk[2] = key[191:128];
    rk[3] = key[255:192];
    for (int i = 4; i < NR; i++) begin
      tmp   = rotr(rk[i-1], 3) ^ rk[i-3];
      tmp   = tmp ^ rotr(tmp, 1);
      rk[i] = ~rk[i-4] ^ tmp ^ {63'd0, z[(i-4) % 62]} ^ 64'd3;
    end
    for (int i = 0; i < 512; i++) mem[i] = (i < NR) ? rk[i] : 64'd0;
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] t;
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < NR; i++) begin
      t = x;
      x = y ^ fr(x) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents ct until accepted; returns just after the accept edge.
  task automatic accept_block(input logic [127:0] ct, input int max_wait, output bit ok);
    ok      = 1'b0;
    ct_data = ct;
    ct_vld  = 1'b1;
    for (int i = 0; i < max_wait; i++) begin
      #1;
      if (ct_rdy) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    ct_vld = 1'b0;
  endtask

  task automatic wait_pt(input int max_cycles, output int cyc, output bit ok);
    cyc = 0;
    while (!pt_vld && cyc < max_cycles) begin
      tick();
      cyc++;
    end
    ok = pt_vld;
  endtask

  task automatic test_reset();
    key_mem_full = 1'b1;
    ct_vld       = 1'b1;
    ct_data      = KAT_CT;
    tick();
    tick();
    n_checks++;
    if (ct_rdy !== 1'b0) $display("FAIL reset_ct_rdy: got %b expected 0", ct_rdy);
    else n_pass++;
    n_checks++;
    if (key_rd_en !== 1'b0) $display("FAIL reset_key_rd_en: got %b expected 0", key_rd_en);
    else n_pass++;
    n_checks++;
    if (key_addr !== 9'd0) $display("FAIL reset_key_addr: got %0d expected 0", key_addr);
    else n_pass++;
    n_checks++;
    if (pt_vld !== 1'b0) $display("FAIL reset_pt_vld: got %b expected 0", pt_vld);
    else n_pass++;
    n_checks++;
    if (pt_err !== 1'b0) $display("FAIL reset_pt_err: got %b expected 0", pt_err);
    else n_pass++;
    n_checks++;
    if (pt_data !== 128'd0) $display("FAIL reset_pt_data: got %h expected 0", pt_data);
    else n_pass++;
    ct_vld = 1'b0;
    rst    = 1'b0;
    #1;
    n_checks++;
    if (ct_rdy !== 1'b1) $display("FAIL idle_ct_rdy: got %b expected 1", ct_rdy);
    else n_pass++;
  endtask

  task automatic test_known_answer();
    bit ok;
    int addr_bad;
    int en_cnt;
    int early;
    int busy_rdy;
    logic [127:0] e;
    expand_key(KAT_KEY);
    pt_rdy       = 1'b1;
    key_mem_full = 1'b1;
    accept_block(KAT_CT, 10, ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL kat_accept: got %b expected 1", ok);
    else n_pass++;
    exp_q.push_back(KAT_PT);
    addr_bad = 0; en_cnt = 0; early = 0; busy_rdy = 0;
    for (int j = 0; j <= NR; j++) begin
      if (j < NR && (key_rd_en !== 1'b1 || key_addr !== 9'(NR - 1 - j))) begin
        if (addr_bad == 0)
          $display("FAIL kat_addr_seq: cycle %0d got en=%b addr=%0d expected en=1 addr=%0d",
                   j, key_rd_en, key_addr, NR - 1 - j);
        addr_bad++;
      end
      if (key_rd_en === 1'b1) en_cnt++;
      if (pt_vld !== 1'b0) early++;
      if (ct_rdy !== 1'b0) busy_rdy++;
      tick();
    end
    n_checks++;
    if (addr_bad !== 0) $display("FAIL kat_addr_errors: got %0d expected 0", addr_bad);
    else n_pass++;
    n_checks++;
    if (en_cnt !== NR) $display("FAIL kat_rd_en_cycles: got %0d expected %0d", en_cnt, NR);
    else n_pass++;
    n_checks++;
    if (early !== 0) $display("FAIL kat_early_pt_vld: got %0d expected 0", early);
    else n_pass++;
    n_checks++;
    if (busy_rdy !== 0) $display("FAIL kat_busy_ct_rdy: got %0d expected 0", busy_rdy);
    else n_pass++;
    n_checks++;
    if (pt_vld !== 1'b1) $display("FAIL kat_latency_73: got pt_vld=%b expected 1", pt_vld);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (pt_data !== e) $display("FAIL kat_pt_data: got %h expected %h", pt_data, e);
    else n_pass++;
    n_checks++;
    if (pt_err !== 1'b0) $display("FAIL kat_pt_err: got %b expected 0", pt_err);
    else n_pass++;
    tick();
    n_checks++;
    if (pt_vld !== 1'b0) $display("FAIL kat_handshake: got pt_vld=%b expected 0", pt_vld);
    else n_pass++;
    n_checks++;
    if (ct_rdy !== 1'b1) $display("FAIL kat_ct_rdy_after: got %b expected 1", ct_rdy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    int busy_rdy;
    int bad;
    logic [127:0] pa, pb, snap, e;
    pa = {$urandom(), $urandom(), $urandom(), $urandom()};
    pb = {$urandom(), $urandom(), $urandom(), $urandom()};
    pt_rdy = 1'b0;
    accept_block(encrypt(pa), 10, ok);
    exp_q.push_back(pa);
    ct_data  = encrypt(pb);
    ct_vld   = 1'b1;
    cyc      = 0;
    busy_rdy = 0;
    while (!pt_vld && cyc < 100) begin
      if (ct_rdy !== 1'b0) busy_rdy++;
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc !== 73) $display("FAIL bp_latency: got %0d expected 73", cyc);
    else n_pass++;
    n_checks++;
    if (busy_rdy !== 0) $display("FAIL bp_busy_ct_rdy: got %0d expected 0", busy_rdy);
    else n_pass++;
    snap = pt_data;
    bad  = 0;
    repeat (20) begin
      tick();
      if (pt_data !== snap || pt_vld !== 1'b1 || ct_rdy !== 1'b0 || key_rd_en !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL bp_stall_stable: got %0d bad cycles expected 0", bad);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (pt_data !== e) $display("FAIL bp_first_data: got %h expected %h", pt_data, e);
    else n_pass++;
    pt_rdy = 1'b1;
    tick();
    pt_rdy = 1'b0;
    n_checks++;
    if (ct_rdy !== 1'b1 || key_rd_en !== 1'b0)
      $display("FAIL bp_post_handshake: got ct_rdy=%b key_rd_en=%b expected 1 0",
               ct_rdy, key_rd_en);
    else n_pass++;
    tick();
    ct_vld = 1'b0;
    exp_q.push_back(pb);
    n_checks++;
    if (key_rd_en !== 1'b1 || key_addr !== 9'd71)
      $display("FAIL bp_second_accept: got en=%b addr=%0d expected 1 71", key_rd_en, key_addr);
    else n_pass++;
    wait_pt(100, cyc, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || pt_data !== e) $display("FAIL bp_second_data: got %h expected %h", pt_data, e);
    else n_pass++;
    pt_rdy = 1'b1;
    tick();
  endtask

  task automatic test_gating();
    bit ok;
    int cyc;
    int bad;
    logic [127:0] p, e;
    p = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_mem_full = 1'b0;
    ct_data      = encrypt(p);
    ct_vld       = 1'b1;
    bad          = 0;
    repeat (8) begin
      #1;
      if (ct_rdy !== 1'b0 || key_rd_en !== 1'b0) bad++;
      tick();
    end
    ct_vld = 1'b0;
    n_checks++;
    if (bad !== 0) $display("FAIL gate_no_accept: got %0d bad cycles expected 0", bad);
    else n_pass++;
    key_mem_full = 1'b1;
    accept_block(encrypt(p), 10, ok);
    key_mem_full = 1'b0;
    exp_q.push_back(p);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL gate_accept_when_full: got %b expected 1", ok);
    else n_pass++;
    wait_pt(100, cyc, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || pt_data !== e)
      $display("FAIL gate_full_drop_completes: got %h expected %h", pt_data, e);
    else n_pass++;
    tick();
    n_checks++;
    if (ct_rdy !== 1'b0) $display("FAIL gate_idle_not_full: got %b expected 0", ct_rdy);
    else n_pass++;
    key_mem_full = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    int bad;
    accept_block(KAT_CT, 10, ok);
    repeat (31) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (ct_rdy !== 1'b0 || key_rd_en !== 1'b0 || key_addr !== 9'd0 || pt_vld !== 1'b0 ||
        pt_err !== 1'b0 || pt_data !== 128'd0)
      $display("FAIL rst_mid_outputs: got rdy=%b en=%b addr=%0d vld=%b err=%b data=%h expected 0",
               ct_rdy, key_rd_en, key_addr, pt_vld, pt_err, pt_data);
    else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    repeat (80) begin
      tick();
      if (pt_vld !== 1'b0 || key_rd_en !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL rst_mid_discard: got %0d bad cycles expected 0", bad);
    else n_pass++;
    accept_block(KAT_CT, 10, ok);
    exp_q.push_back(KAT_PT);
    wait_pt(100, cyc, ok);
    n_checks++;
    if (!ok || cyc !== 73) $display("FAIL rst_mid_rerun_latency: got %0d expected 73", cyc);
    else n_pass++;
    n_checks++;
    if (pt_data !== exp_q[0])
      $display("FAIL rst_mid_rerun_data: got %h expected %h", pt_data, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    pt_rdy = 1'b1;
    tick();
  endtask

  task automatic test_key_check();
    bit ok;
    int cyc;
    logic [127:0] p, e;
    p      = {$urandom(), $urandom(), $urandom(), $urandom()};
    pt_rdy = 1'b0;
    accept_block(encrypt(p), 10, ok);
    exp_q.push_back(p);
    repeat (5) tick();
    key_data_vld = 1'b0;
    tick();
    key_data_vld = 1'b1;
    wait_pt(100, cyc, ok);
    n_checks++;
    if (!ok || cyc + 6 !== 73) $display("FAIL kchk_latency: got %0d expected 73", cyc + 6);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (pt_data !== e) $display("FAIL kchk_data: got %h expected %h", pt_data, e);
    else n_pass++;
`ifdef SIMON128_256_DECRYPT_KEY_CHECK_EN
    n_checks++;
    if (pt_err !== 1'b1) $display("FAIL kchk_err_set: got %b expected 1", pt_err);
    else n_pass++;
`else
    n_checks++;
    if (pt_err !== 1'b0) $display("FAIL kchk_err_ignored: got %b expected 0", pt_err);
    else n_pass++;
`endif
    pt_rdy = 1'b1;
    tick();
    n_checks++;
    if (pt_err !== 1'b0) $display("FAIL kchk_err_idle: got %b expected 0", pt_err);
    else n_pass++;
    accept_block(KAT_CT, 10, ok);
    wait_pt(100, cyc, ok);
    n_checks++;
    if (!ok || pt_err !== 1'b0 || pt_data !== KAT_PT)
      $display("FAIL kchk_next_clean: got err=%b data=%h expected err=0 data=%h",
               pt_err, pt_data, KAT_PT);
    else n_pass++;
    tick();
  endtask

  task automatic test_round_trip();
    logic [127:0] pts [0:99];
    logic [127:0] cts [0:99];
    logic [127:0] e;
    int  sent;
    int  recv;
    int  cyc;
    bit  acc;
    expand_key({$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()});
    for (int i = 0; i < 100; i++) begin
      pts[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      cts[i] = encrypt(pts[i]);
    end
    sent = 0; recv = 0; cyc = 0;
    ct_vld = 1'b0;
    while (recv < 100 && cyc < 40000) begin
      if (!ct_vld && sent < 100 && $urandom_range(0, 3) != 0) begin
        ct_data = cts[sent];
        ct_vld  = 1'b1;
      end
      pt_rdy = 1'($urandom_range(0, 1));
      #1;
      acc = ct_vld && ct_rdy;
      if (acc) begin
        exp_q.push_back(pts[sent]);
        sent++;
      end
      if (pt_vld && pt_rdy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rt_unexpected_output: got %h expected none", pt_data);
        end else begin
          e = exp_q.pop_front();
          if (pt_data !== e) $display("FAIL rt_data %0d: got %h expected %h", recv, pt_data, e);
          else n_pass++;
        end
        recv++;
      end
      tick();
      if (acc) ct_vld = 1'b0;
      cyc++;
    end
    ct_vld = 1'b0;
    n_checks++;
    if (recv !== 100) $display("FAIL rt_count: got %0d expected 100", recv);
    else n_pass++;
  endtask

  initial begin
    key_mem_full = 1'b0;
    key_data_vld = 1'b1;
    ct_data      = '0;
    ct_vld       = 1'b0;
    pt_rdy       = 1'b0;
    test_reset();
    test_known_answer();
    test_backpressure();
    test_gating();
    test_reset_mid();
    test_key_check();
    test_round_trip();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
